// File: rtl/rv32i_types.sv
// Shared RV32I decode types: branch compare ops and the branch reservation entry layout.
package rv32i_types;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    // Operand fields carry the value when the matching v bit is set, else a ROB tag in the low bits.
    typedef struct packed {
        logic [31:0]    opa;
        logic           v1;
        logic [31:0]    opb;
        logic           v2;
        logic [31:0]    pc_next_reg;
        logic           v3;
        logic [31:0]    imm;
        logic [31:0]    pc;
        branch_funct3_t cmpop;
    } br_rs_entry_t;

endpackage

// File: rtl/cmp.sv
// Branch comparator: evaluates the RV32I conditional-branch compare for one operand pair.
module cmp
    import rv32i_types::*;
(
    input  branch_funct3_t cmpop,
    input  logic [31:0]    in_A,
    input  logic [31:0]    in_B,
    output logic           br_en
);

    always_comb begin
        br_en = 1'b0;
        case (cmpop)
            beq:     br_en = (in_A == in_B);
            bne:     br_en = (in_A != in_B);
            blt:     br_en = ($signed(in_A) < $signed(in_B));
            bge:     br_en = ($signed(in_A) >= $signed(in_B));
            bltu:    br_en = (in_A < in_B);
            bgeu:    br_en = (in_A >= in_B);
            default: br_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_resv_queue.sv
// In-order branch reservation queue: captures operands from the ROB and resolves the oldest
// branch each cycle, redirecting fetch on a mispredict and latching halt on a self-loop.
module br_resv_queue
    import rv32i_types::*;
#(
    parameter int unsigned ROB_SIZE     = 16,
    parameter int unsigned ROB_IDX_BITS = 4,
    parameter int unsigned RS_DEPTH     = 4,
    parameter int unsigned RS_IDX_BITS  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_br_dec,
    input  logic [31:0]                  opA_br_dec,
    input  logic [31:0]                  opB_br_dec,
    input  logic [31:0]                  PC_next_reg_dec,
    input  logic [31:0]                  imm_br_dec,
    input  logic                         v1_br_dec,
    input  logic                         v2_br_dec,
    input  logic                         v3_br_dec,
    input  branch_funct3_t               cmpop_dec,
    input  logic [31:0]                  PC_dec,
    input  logic [ROB_SIZE-1:0]          done_rob,
    input  logic [ROB_SIZE-1:0][31:0]    data_rob,
    input  logic [31:0]                  PC_iq_head,
    input  logic                         iq_empty,
    output logic                         brrs_full,
    output logic [RS_IDX_BITS:0]         brrs_count,
    output logic                         resolve_valid,
    output logic [31:0]                  pc_brrs,
    output logic [31:0]                  pc_curr_brrs,
    output logic                         flush,
    output logic                         halt
);

    localparam int unsigned CntW = RS_IDX_BITS + 1;
    localparam logic [CntW-1:0]        CntOne  = CntW'(1);
    localparam logic [CntW-1:0]        CntFull = CntW'(RS_DEPTH);
    localparam logic [RS_IDX_BITS-1:0] PtrOne  = RS_IDX_BITS'(1);

    logic [RS_IDX_BITS-1:0] head_q, tail_q;
    logic [CntW-1:0]        count_q;
    logic                   halt_q;

    logic [RS_DEPTH-1:0]    valid_vec;
    br_rs_entry_t           entry_vec [RS_DEPTH];
    br_rs_entry_t           head_e;
    br_rs_entry_t           new_e;
    logic                   ready;
    logic                   do_load;
    logic                   br_en;
    logic [31:0]            next_pc;

    assign brrs_full  = (count_q == CntFull);
    assign brrs_count = count_q;
    assign do_load    = load_br_dec && !brrs_full;

    assign head_e = entry_vec[head_q];
    assign ready  = valid_vec[head_q] && head_e.v1 && head_e.v2 && head_e.v3;

    cmp u_cmp (
        .cmpop (head_e.cmpop),
        .in_A  (head_e.opa),
        .in_B  (head_e.opb),
        .br_en (br_en)
    );

    assign next_pc       = br_en ? (head_e.pc_next_reg + head_e.imm) : (head_e.pc + 32'd4);
    assign resolve_valid = ready;
    assign pc_brrs       = next_pc;
    assign pc_curr_brrs  = head_e.pc;
    assign flush         = ready && (iq_empty || (PC_iq_head != next_pc));
    assign halt          = halt_q;

    always_comb begin
        new_e             = '0;
        new_e.opa         = opA_br_dec;
        new_e.v1          = v1_br_dec;
        new_e.opb         = opB_br_dec;
        new_e.v2          = v2_br_dec;
        new_e.pc_next_reg = PC_next_reg_dec;
        new_e.v3          = v3_br_dec;
        new_e.imm         = imm_br_dec;
        new_e.pc          = PC_dec;
        new_e.cmpop       = cmpop_dec;
    end

    for (genvar i = 0; i < RS_DEPTH; i++) begin : g_entry
        localparam logic [RS_IDX_BITS-1:0] Idx = RS_IDX_BITS'(i);

        br_rs_entry_t            entry_q;
        br_rs_entry_t            entry_woken;
        logic                    valid_q;
        logic [ROB_IDX_BITS-1:0] tag_a, tag_b, tag_n;

        assign tag_a = entry_q.opa[ROB_IDX_BITS-1:0];
        assign tag_b = entry_q.opb[ROB_IDX_BITS-1:0];
        assign tag_n = entry_q.pc_next_reg[ROB_IDX_BITS-1:0];

        always_comb begin
            entry_woken = entry_q;
            if (valid_q && !entry_q.v1 && done_rob[tag_a]) begin
                entry_woken.opa = data_rob[tag_a];
                entry_woken.v1  = 1'b1;
            end
            if (valid_q && !entry_q.v2 && done_rob[tag_b]) begin
                entry_woken.opb = data_rob[tag_b];
                entry_woken.v2  = 1'b1;
            end
            if (valid_q && !entry_q.v3 && done_rob[tag_n]) begin
                entry_woken.pc_next_reg = data_rob[tag_n];
                entry_woken.v3          = 1'b1;
            end
        end

        // A fresh allocation takes the decoder fields verbatim; wakeup starts next cycle.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                valid_q <= 1'b0;
            end else if (do_load && (tail_q == Idx)) begin
                entry_q <= new_e;
                valid_q <= 1'b1;
            end else begin
                entry_q <= entry_woken;
                if (ready && (head_q == Idx)) begin
                    valid_q <= 1'b0;
                end
            end
        end

        assign valid_vec[i] = valid_q;
        assign entry_vec[i] = entry_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            halt_q  <= 1'b0;
        end else if (flush) begin
            head_q  <= tail_q;
            count_q <= '0;
            if (next_pc == head_e.pc) begin
                halt_q <= 1'b1;
            end
        end else begin
            if (ready) begin
                head_q <= head_q + PtrOne;
            end
            if (do_load) begin
                tail_q <= tail_q + PtrOne;
            end
            case ({do_load, ready})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_br_resv_queue.sv
// Self-checking bench for br_resv_queue: directed scenarios plus random traffic, checked
// against a queue-level model by a negedge monitor.
module tb_br_resv_queue;
    import rv32i_types::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                load_br_dec;
    logic [31:0]         opA_br_dec, opB_br_dec, PC_next_reg_dec, imm_br_dec, PC_dec;
    logic                v1_br_dec, v2_br_dec, v3_br_dec;
    branch_funct3_t      cmpop_dec;
    logic [15:0]         done_rob;
    logic [15:0][31:0]   data_rob;
    logic [31:0]         PC_iq_head;
    logic                iq_empty;
    logic                brrs_full;
    logic [2:0]          brrs_count;
    logic                resolve_valid, flush, halt;
    logic [31:0]         pc_brrs, pc_curr_brrs;

    always #5 clk = ~clk;

    br_resv_queue dut (
        .clk             (clk),
        .rst             (rst),
        .load_br_dec     (load_br_dec),
        .opA_br_dec      (opA_br_dec),
        .opB_br_dec      (opB_br_dec),
        .PC_next_reg_dec (PC_next_reg_dec),
        .imm_br_dec      (imm_br_dec),
        .v1_br_dec       (v1_br_dec),
        .v2_br_dec       (v2_br_dec),
        .v3_br_dec       (v3_br_dec),
        .cmpop_dec       (cmpop_dec),
        .PC_dec          (PC_dec),
        .done_rob        (done_rob),
        .data_rob        (data_rob),
        .PC_iq_head      (PC_iq_head),
        .iq_empty        (iq_empty),
        .brrs_full       (brrs_full),
        .brrs_count      (brrs_count),
        .resolve_valid   (resolve_valid),
        .pc_brrs         (pc_brrs),
        .pc_curr_brrs    (pc_curr_brrs),
        .flush           (flush),
        .halt            (halt)
    );

    typedef struct {
        logic [31:0] a, b, n, imm, pc;
        bit          va, vb, vn;
        logic [2:0]  op;
    } br_t;

    br_t         mq[$];       // branches the queue should currently hold, oldest first
    br_t         issue_q[$];  // branches presented by the stimulus, awaiting accept/drop
    logic [31:0] rob_tbl [16];
    int          checks = 0;
    int          errors = 0;
    bit          halt_m = 1'b0;
    bit          auto_iq = 1'b0;
    logic [2:0]  ops [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

    function automatic logic [31:0] opval(logic [31:0] x, bit v);
        return v ? x : rob_tbl[x[3:0]];
    endfunction

    function automatic logic [31:0] exp_pc(br_t e);
        logic [31:0] a, b;
        bit t;
        a = opval(e.a, e.va);
        b = opval(e.b, e.vb);
        case (e.op)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t ? (opval(e.n, e.vn) + e.imm) : (e.pc + 32'd4);
    endfunction

    function automatic bit ready_m();
        return (mq.size() > 0) && mq[0].va && mq[0].vb && mq[0].vn;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare this cycle's outputs, then advance the model across the coming edge.
    always @(negedge clk) begin
        br_t         h, nb;
        logic [31:0] px;
        bit          rv, fl, have_nb;
        int          sz;
        rv = ready_m();
        fl = 1'b0;
        px = '0;
        chk("count", 32'(brrs_count), 32'(mq.size()));
        chk("full", 32'(brrs_full), 32'(mq.size() == 4));
        chk("resolve_valid", 32'(resolve_valid), 32'(rv));
        chk("halt", 32'(halt), 32'(halt_m));
        if (rv) begin
            h  = mq[0];
            px = exp_pc(h);
            fl = iq_empty || (PC_iq_head != px);
            chk("pc_brrs", pc_brrs, px);
            chk("pc_curr_brrs", pc_curr_brrs, h.pc);
            chk("flush", 32'(flush), 32'(fl));
        end else begin
            chk("flush_idle", 32'(flush), 32'd0);
        end
        have_nb = 1'b0;
        if (load_br_dec && issue_q.size() > 0) begin
            nb      = issue_q.pop_front();
            have_nb = 1'b1;
        end
        if (rst) begin
            mq.delete();
            halt_m = 1'b0;
        end else if (rv && fl) begin
            if (px == h.pc) halt_m = 1'b1;
            mq.delete();
        end else begin
            sz = mq.size();
            foreach (mq[i]) begin
                if (!mq[i].va && done_rob[mq[i].a[3:0]]) begin
                    mq[i].a = rob_tbl[mq[i].a[3:0]]; mq[i].va = 1'b1;
                end
                if (!mq[i].vb && done_rob[mq[i].b[3:0]]) begin
                    mq[i].b = rob_tbl[mq[i].b[3:0]]; mq[i].vb = 1'b1;
                end
                if (!mq[i].vn && done_rob[mq[i].n[3:0]]) begin
                    mq[i].n = rob_tbl[mq[i].n[3:0]]; mq[i].vn = 1'b1;
                end
            end
            if (rv) void'(mq.pop_front());
            if (have_nb && sz < 4) mq.push_back(nb);
        end
    end

    task automatic set_iq();
        if (ready_m() && $urandom_range(0, 4) != 0) PC_iq_head = exp_pc(mq[0]);
        else PC_iq_head = 32'($urandom_range(0, 1023)) * 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        load_br_dec = 1'b0;
        done_rob    = '0;
        if (auto_iq) set_iq();
    endtask

    task automatic set_branch(input logic [2:0] op, input logic [31:0] a, input bit va,
                              input logic [31:0] b, input bit vb, input logic [31:0] n,
                              input bit vn, input logic [31:0] imm, input logic [31:0] pc);
        br_t e;
        load_br_dec     = 1'b1;
        cmpop_dec       = branch_funct3_t'(op);
        opA_br_dec      = a;  v1_br_dec = va;
        opB_br_dec      = b;  v2_br_dec = vb;
        PC_next_reg_dec = n;  v3_br_dec = vn;
        imm_br_dec      = imm;
        PC_dec          = pc;
        e.a = a; e.b = b; e.n = n; e.imm = imm; e.pc = pc;
        e.va = va; e.vb = vb; e.vn = vn; e.op = op;
        issue_q.push_back(e);
    endtask

    function automatic logic [31:0] small_val();
        int v;
        v = int'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) v = -v;
        return 32'(v);
    endfunction

    function automatic logic [31:0] rand_field(bit v);
        logic [31:0] r;
        r = $urandom;
        return v ? small_val() : {r[31:4], 4'($urandom_range(0, 15))};
    endfunction

    task automatic drain();
        auto_iq = 1'b1;
        for (int k = 0; k < 40 && mq.size() > 0; k++) begin
            done_rob = '1;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; load_br_dec = 1'b0; done_rob = '0; iq_empty = 1'b0; PC_iq_head = '0;
        opA_br_dec = '0; opB_br_dec = '0; PC_next_reg_dec = '0; imm_br_dec = '0; PC_dec = '0;
        v1_br_dec = 1'b0; v2_br_dec = 1'b0; v3_br_dec = 1'b0; cmpop_dec = beq;
        for (int i = 0; i < 16; i++) rob_tbl[i] = small_val();
        rob_tbl[3] = 32'd9;
        for (int i = 0; i < 16; i++) data_rob[i] = rob_tbl[i];
        tick(); tick();
        rst = 1'b0;

        // Taken beq to 0x120 while fetch predicted 0x64: mispredict.
        PC_iq_head = 32'h64;
        set_branch(3'b000, 32'd5, 1, 32'd5, 1, 32'h100, 1, 32'h20, 32'h60);
        tick(); tick(); tick();

        // Not-taken bne predicted correctly, with a younger waiting branch behind it.
        PC_iq_head = 32'h84;
        set_branch(3'b001, 32'd7, 1, 32'd7, 1, 32'h200, 1, 32'h8, 32'h80);
        tick();
        set_branch(3'b000, 32'h2, 0, 32'd1, 1, 32'h300, 1, 32'h4, 32'ha0);
        tick(); tick(); tick();
        drain();

        // Four loads with a blocked head, a refused fifth, then wakeup of tag 3.
        auto_iq = 1'b1;
        set_branch(3'b000, 32'h3, 0, 32'd9, 1, 32'h400, 1, 32'h10, 32'h100);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_branch(3'b001, 32'd1, 1, 32'd1, 1, 32'h0, 1, 32'h0, 32'h104 + 32'(4 * i));
            tick();
        end
        set_branch(3'b000, 32'd1, 1, 32'd1, 1, 32'h0, 1, 32'h0, 32'h200);
        tick(); tick();
        done_rob[3] = 1'b1;
        tick(); tick(); tick(); tick(); tick(); tick();

        // Three queued behind a blocked head that then mispredicts; load in flush cycle.
        auto_iq = 1'b0;
        PC_iq_head = 32'hdead0000;
        set_branch(3'b000, 32'h4, 0, 32'd0, 1, 32'h500, 1, 32'h0, 32'h300);
        tick();
        set_branch(3'b001, 32'd2, 1, 32'd3, 1, 32'h600, 1, 32'h0, 32'h304);
        tick();
        set_branch(3'b001, 32'd2, 1, 32'd3, 1, 32'h600, 1, 32'h0, 32'h308);
        tick();
        done_rob[4] = 1'b1;
        tick();
        set_branch(3'b001, 32'd1, 1, 32'd2, 1, 32'h700, 1, 32'h0, 32'h30c);
        tick(); tick();

        // Load at count 3 while the head resolves correctly.
        auto_iq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_branch(3'b001, 32'h5, i != 0, 32'd0, 1, 32'h0, 1, 32'h0, 32'h800 + 32'(4 * i));
            tick();
        end
        done_rob[5] = 1'b1;
        tick();
        PC_iq_head = exp_pc(mq[0]);
        set_branch(3'b101, 32'd3, 1, 32'd3, 1, 32'h900, 1, 32'h4, 32'h80c);
        tick();
        drain();

        // Self-loop with an empty IQ latches halt until reset.
        auto_iq = 1'b0;
        iq_empty = 1'b1;
        set_branch(3'b000, 32'd1, 1, 32'd1, 1, 32'h40, 1, 32'h0, 32'h40);
        tick(); tick(); tick();
        iq_empty = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Random traffic.
        auto_iq = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            bit va, vb, vn;
            va = $urandom_range(0, 2) != 0;
            vb = $urandom_range(0, 2) != 0;
            vn = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 1) == 1)
                set_branch(ops[$urandom_range(0, 5)], rand_field(va), va, rand_field(vb), vb,
                           vn ? 32'($urandom_range(0, 255)) * 32'd4 : rand_field(1'b0), vn,
                           32'($urandom_range(0, 63)) * 32'd4,
                           32'($urandom_range(0, 1023)) * 32'd4);
            for (int t = 0; t < 16; t++) done_rob[t] = ($urandom_range(0, 3) == 0);
            iq_empty = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        iq_empty = 1'b0;
        drain();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
